// File: rtl/dxm_stream_demux.sv
// Packet-aware 1-to-2 valid/ready demultiplexer. Route is latched on the first
// beat of a packet and held until in_last; each output has a one-entry register.

module dxm_demux_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         lin,
  input  logic         drain,
  output logic [W-1:0] data,
  output logic         last,
  output logic         valid
);
  // Load wins over drain so a back-to-back beat keeps valid high with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
      last  <= lin;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end
endmodule

module dxm_stream_demux #(
  parameter int mux_width = 1,
  parameter bit LOCK_PKT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [mux_width-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 control,
  output logic [mux_width-1:0] out_low_data,
  output logic                 out_low_last,
  output logic                 out_low_valid,
  input  logic                 out_low_ready,
  output logic [mux_width-1:0] out_high_data,
  output logic                 out_high_last,
  output logic                 out_high_valid,
  input  logic                 out_high_ready,
  output logic                 busy,
  output logic                 sel_err,
  input  logic                 err_clr
);
  localparam int NPORT = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RT_LOW = 2'd1, RT_HIGH = 2'd2} state_t;

  state_t state, state_nxt;
  logic   eff_sel, accept, lock_mis;

  logic [NPORT-1:0]                slot_vld, slot_rdy, slot_last, slot_free, slot_load;
  logic [NPORT-1:0][mux_width-1:0] slot_data;

  assign slot_rdy  = {out_high_ready, out_low_ready};
  assign slot_free = ~slot_vld | slot_rdy;

  always_comb begin
    state_nxt = state;
    slot_load = '0;
    case (state)
      RT_LOW:  eff_sel = 1'b0;
      RT_HIGH: eff_sel = 1'b1;
      default: eff_sel = control;
    endcase
    // Only the targeted slot gates the input; the other port drains on its own.
    in_ready = slot_free[eff_sel];
    accept   = in_valid & in_ready;
    slot_load[eff_sel] = accept;
    if (LOCK_PKT && accept) begin
      if (in_last)
        state_nxt = IDLE;
      else if (state == IDLE)
        state_nxt = eff_sel ? RT_HIGH : RT_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign lock_mis = LOCK_PKT && (state != IDLE) && in_valid &&
                    (control != (state == RT_HIGH));

  always_ff @(posedge clk) begin
    if (rst)           sel_err <= 1'b0;
    else if (lock_mis) sel_err <= 1'b1;
    else if (err_clr)  sel_err <= 1'b0;
  end

  assign busy = (state != IDLE);

  for (genvar g = 0; g < NPORT; g++) begin : g_slot
    dxm_demux_slot #(.W(mux_width)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (slot_load[g]),
      .din   (in_data),
      .lin   (in_last),
      .drain (slot_rdy[g]),
      .data  (slot_data[g]),
      .last  (slot_last[g]),
      .valid (slot_vld[g])
    );
  end

  assign out_low_data   = slot_data[0];
  assign out_low_last   = slot_last[0];
  assign out_low_valid  = slot_vld[0];
  assign out_high_data  = slot_data[1];
  assign out_high_last  = slot_last[1];
  assign out_high_valid = slot_vld[1];
endmodule

// File: tb/tb_dxm_stream_demux.sv
// Bench for dxm_stream_demux: a packet-locked and a per-beat instance share one
// stimulus; a queue-based reference model predicts every output each cycle.

module tb_dxm_stream_demux;
  localparam int W  = 8;
  localparam int BW = W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_last, control, lo_rdy, hi_rdy, err_clr;
  logic [W-1:0] in_data;

  logic [1:0]   ir_w, lov_w, lol_w, hiv_w, hil_w, busy_w, err_w;
  logic [W-1:0] lod_w [2];
  logic [W-1:0] hid_w [2];

  dxm_stream_demux #(.mux_width(W), .LOCK_PKT(1'b1)) u_lock (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir_w[0]), .control(control),
    .out_low_data(lod_w[0]), .out_low_last(lol_w[0]), .out_low_valid(lov_w[0]),
    .out_low_ready(lo_rdy),
    .out_high_data(hid_w[0]), .out_high_last(hil_w[0]), .out_high_valid(hiv_w[0]),
    .out_high_ready(hi_rdy),
    .busy(busy_w[0]), .sel_err(err_w[0]), .err_clr(err_clr)
  );

  dxm_stream_demux #(.mux_width(W), .LOCK_PKT(1'b0)) u_free (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir_w[1]), .control(control),
    .out_low_data(lod_w[1]), .out_low_last(lol_w[1]), .out_low_valid(lov_w[1]),
    .out_low_ready(lo_rdy),
    .out_high_data(hid_w[1]), .out_high_last(hil_w[1]), .out_high_valid(hiv_w[1]),
    .out_high_ready(hi_rdy),
    .busy(busy_w[1]), .sel_err(err_w[1]), .err_clr(err_clr)
  );

  // Reference model: per instance, per port FIFO of {last,data} not yet consumed.
  logic [W:0] mq [4][$];
  bit inpkt [2];
  bit route [2];
  bit err   [2];
  int checks, errors;

  function automatic bit msel(int d);
    return (d == 0 && inpkt[0]) ? route[0] : control;
  endfunction

  function automatic bit mready(int d);
    bit s = msel(d);
    return (mq[d*2 + int'(s)].size() == 0) || (s ? hi_rdy : lo_rdy);
  endfunction

  task automatic chk(string nm, int d, logic [W:0] act, logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h want %h", nm, d, act, exp);
    end
  endtask

  task automatic check_dut(int d);
    chk("in_ready", d, BW'(ir_w[d]), BW'(mready(d)));
    chk("lo_valid", d, BW'(lov_w[d]), BW'(mq[d*2].size() != 0));
    if (mq[d*2].size() != 0) chk("lo_beat", d, {lol_w[d], lod_w[d]}, mq[d*2][0]);
    chk("hi_valid", d, BW'(hiv_w[d]), BW'(mq[d*2+1].size() != 0));
    if (mq[d*2+1].size() != 0) chk("hi_beat", d, {hil_w[d], hid_w[d]}, mq[d*2+1][0]);
    chk("busy", d, BW'(busy_w[d]), BW'(inpkt[d]));
    chk("sel_err", d, BW'(err_w[d]), BW'(err[d]));
  endtask

  task automatic update(int d);
    bit s, ir;
    if (rst) begin
      mq[d*2].delete();
      mq[d*2+1].delete();
      inpkt[d] = 1'b0;
      err[d]   = 1'b0;
      return;
    end
    s  = msel(d);
    ir = mready(d);
    if (d == 0 && inpkt[0] && in_valid && control != route[0]) err[0] = 1'b1;
    else if (err_clr) err[d] = 1'b0;
    if (mq[d*2].size() != 0 && lo_rdy) void'(mq[d*2].pop_front());
    if (mq[d*2+1].size() != 0 && hi_rdy) void'(mq[d*2+1].pop_front());
    if (in_valid && ir) begin
      mq[d*2 + int'(s)].push_back({in_last, in_data});
      if (d == 0) begin
        if (!inpkt[0] && !in_last) begin
          inpkt[0] = 1'b1;
          route[0] = control;
        end else if (inpkt[0] && in_last) begin
          inpkt[0] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_phase();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic update_phase();
    @(posedge clk);
    update(0);
    update(1);
    #1;
  endtask

  task automatic step();
    check_phase();
    update_phase();
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] dd, input logic lst, input logic ctl);
    in_valid = iv;
    in_data  = dd;
    in_last  = lst;
    control  = ctl;
    step();
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ctl;
    logic         lov;
    logic [W-1:0] lod;
    logic         hiv;
    logic [W-1:0] hid;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Single-beat packets alternating ports; outputs show the previous cycle's beat.
    vecs = '{
      '{1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0},
      '{1'b1, 8'd2, 1'b1, 1'b1, 8'd1, 1'b0, 8'd0},
      '{1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b1, 8'd2},
      '{1'b1, 8'd4, 1'b1, 1'b1, 8'd3, 1'b0, 8'd0},
      '{1'b1, 8'd5, 1'b0, 1'b0, 8'd0, 1'b1, 8'd4},
      '{1'b1, 8'd6, 1'b1, 1'b1, 8'd5, 1'b0, 8'd0},
      '{1'b1, 8'd7, 1'b0, 1'b0, 8'd0, 1'b1, 8'd6},
      '{1'b1, 8'd8, 1'b1, 1'b1, 8'd7, 1'b0, 8'd0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd8},
      '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0}
    };
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; control = 1'b0;
    lo_rdy = 1'b1; hi_rdy = 1'b1; err_clr = 1'b0;

    // T1 reset
    update_phase();
    update_phase();
    rst = 1'b0;
    chk("t1_in_ready", 0, BW'(ir_w[0]), BW'(1'b1));
    chk("t1_lo_valid", 0, BW'(lov_w[0]), BW'(1'b0));
    chk("t1_hi_valid", 0, BW'(hiv_w[0]), BW'(1'b0));
    chk("t1_sel_err", 0, BW'(err_w[0]), BW'(1'b0));
    chk("t1_busy", 0, BW'(busy_w[0]), BW'(1'b0));
    step();

    // T2 table-driven single beats
    in_last = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = vecs[k].iv;
      in_data  = vecs[k].d;
      control  = vecs[k].ctl;
      check_phase();
      chk("t2_in_ready", 0, BW'(ir_w[0]), BW'(1'b1));
      chk("t2_lo_valid", 0, BW'(lov_w[0]), BW'(vecs[k].lov));
      if (vecs[k].lov) chk("t2_lo_data", 0, BW'(lod_w[0]), BW'(vecs[k].lod));
      chk("t2_hi_valid", 0, BW'(hiv_w[0]), BW'(vecs[k].hiv));
      if (vecs[k].hiv) chk("t2_hi_data", 0, BW'(hid_w[0]), BW'(vecs[k].hid));
      update_phase();
    end

    // T3 packet lock with control changing after beat 0
    drive(1'b1, 8'h31, 1'b0, 1'b1);
    chk("t3_busy0", 0, BW'(busy_w[0]), BW'(1'b1));
    chk("t3_hi_data0", 0, BW'(hid_w[0]), BW'(8'h31));
    drive(1'b1, 8'h32, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    chk("t3_hi_data2", 0, BW'(hid_w[0]), BW'(8'h33));
    drive(1'b1, 8'h34, 1'b1, 1'b0);
    chk("t3_hi_last", 0, {hil_w[0], hid_w[0]}, {1'b1, 8'h34});
    chk("t3_busy_end", 0, BW'(busy_w[0]), BW'(1'b0));
    chk("t3_sel_err", 0, BW'(err_w[0]), BW'(1'b1));
    err_clr = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    err_clr = 1'b0;
    chk("t3_err_clr", 0, BW'(err_w[0]), BW'(1'b0));

    // T4 backpressure on the high port
    hi_rdy = 1'b0;
    drive(1'b1, 8'h41, 1'b1, 1'b1);
    in_data = 8'h42;
    chk("t4_stall", 0, BW'(ir_w[0]), BW'(1'b0));
    chk("t4_hold", 0, BW'(hid_w[0]), BW'(8'h41));
    for (int i = 0; i < 3; i++) step();
    hi_rdy = 1'b1;
    step();
    chk("t4_release", 0, BW'(hid_w[0]), BW'(8'h42));
    drive(1'b1, 8'h43, 1'b1, 1'b0);
    chk("t4_low", 0, BW'(lod_w[0]), BW'(8'h43));
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // T5 reset mid-packet
    drive(1'b1, 8'h51, 1'b0, 1'b1);
    drive(1'b1, 8'h52, 1'b0, 1'b1);
    rst = 1'b1;
    drive(1'b1, 8'h53, 1'b0, 1'b1);
    rst = 1'b0;
    chk("t5_busy", 0, BW'(busy_w[0]), BW'(1'b0));
    chk("t5_hi_valid", 0, BW'(hiv_w[0]), BW'(1'b0));
    chk("t5_lo_valid", 0, BW'(lov_w[0]), BW'(1'b0));
    drive(1'b1, 8'h54, 1'b1, 1'b0);
    chk("t5_low", 0, {lov_w[0], lod_w[0]}, {1'b1, 8'h54});
    chk("t5_hi_empty", 0, BW'(hiv_w[0]), BW'(1'b0));

    // T6 per-beat routing on the unlocked instance
    drive(1'b1, 8'h61, 1'b0, 1'b0);
    chk("t6_low", 1, BW'(lod_w[1]), BW'(8'h61));
    drive(1'b1, 8'h62, 1'b0, 1'b1);
    chk("t6_high", 1, {hiv_w[1], hid_w[1]}, {1'b1, 8'h62});
    drive(1'b1, 8'h63, 1'b0, 1'b0);
    drive(1'b1, 8'h64, 1'b1, 1'b1);
    chk("t6_sel_err", 1, BW'(err_w[1]), BW'(1'b0));
    chk("t6_busy", 1, BW'(busy_w[1]), BW'(1'b0));
    err_clr = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    err_clr = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
      in_last  = ($urandom_range(0, 2) == 0);
      control  = ($urandom_range(0, 3) == 0) ? ~control : control;
      lo_rdy   = ($urandom_range(0, 3) != 0);
      hi_rdy   = ($urandom_range(0, 3) != 0);
      err_clr  = ($urandom_range(0, 15) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
